lz77_code_feeder: RTL
=====================

Name: lz77_code_feeder

Overview:
- Upstream stage of the LZ77 decoder.
- Buffers (pos, len, char) codewords in a FIFO and presents one codeword at a time on code_pos/code_len/chardata.
- Holds each codeword for exactly code_len+1 cycles, matching the decoder's output cadence: code_len back-reference chars, then the literal char.
- Detects the end-of-stream literal '$' (8'h24) and parks until the decoder reports finish.

Parameters:
- DEPTH, 8, FIFO depth in codewords; power of two, ≥2.
- END_CHAR, 8'h24, literal value that marks the last codeword of a stream.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream codeword present.
- in_ready  output  1  FIFO can accept a codeword this cycle.
- in_pos  input  4  search-buffer position of the incoming codeword.
- in_len  input  3  match length of the incoming codeword.
- in_char  input  8  next literal of the incoming codeword.
- code_pos  output  4  codeword position driven to the decoder.
- code_len  output  3  codeword length driven to the decoder.
- chardata  output  8  codeword literal driven to the decoder.
- code_valid  output  1  high for every cycle of a codeword's hold window.
- code_first  output  1  one-cycle pulse in the first cycle of each hold window.
- stream_end  output  1  END_CHAR codeword fully issued; feeder parked.
- dec_finish  input  1  decoder finish flag.
- fifo_count  output  $clog2(DEPTH)+1  codewords currently stored.

Behaviour:
- All state and outputs are reset asynchronously when reset=0. Reset values:
  - code_pos, code_len, chardata = 0
  - code_valid, code_first, stream_end = 0
  - fifo_count = 0
  - state = IDLE
  - in_ready = 1 from the first cycle after reset deasserts.
- Reset asserted mid-stream discards the FIFO contents and the hold counter immediately.
- FIFO push: in_valid & in_ready at a rising edge stores {in_pos,in_len,in_char}.
  - in_ready = (fifo_count < DEPTH) & (state != END), decoded from registered state only.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full; fifo_count is unchanged in that case.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- No bypass: a codeword written at edge N is presented on the outputs at the earliest from edge N+1.
- Hold counter cnt is 3 bits and is loaded with the popped len. The hold window is len+1 cycles (1..8).
- State machine:
  - IDLE:
    - code_valid = 0; outputs keep their last values.
    - If fifo_count > 0: pop, register the fields onto the outputs, set cnt = len, pulse code_first, go to HOLD.
  - HOLD:
    - code_valid = 1.
    - If cnt != 0: cnt decrements.
    - Else, if chardata == END_CHAR: go to END.
    - Else, if fifo_count > 0: pop the next codeword back-to-back (no idle cycle), reload cnt, pulse code_first, stay in HOLD.
    - Else: go to IDLE.
  - END:
    - stream_end = 1, code_valid = 0, no pops, in_ready = 0.
    - On dec_finish = 1: go to IDLE and clear stream_end at that edge. FIFO contents are preserved for the next stream.
- An END_CHAR codeword with len > 0 still gets its full len+1 window before entering END.
- dec_finish is ignored outside END.

Decomposition:
- Package lz77_pkg holds:
  - typedef code_t {logic [3:0] pos; logic [2:0] len; logic [7:0] ch;}
  - END_CHAR constant
  - state enum {IDLE, HOLD, END}
- One sub-module: lz77_code_fifo, a synchronous DEPTH-entry FIFO of code_t with push, pop, full, empty and count.
- The feeder FSM and hold counter stay in lz77_code_feeder.

Test Plan:
- Reset: release reset with the FIFO empty → in_ready=1, code_valid=0, fifo_count=0, all codeword outputs 0.
- Single codeword: push (pos=3, len=2, char=8'h41) → code_valid high exactly 3 cycles; code_first only in the first; outputs 3/2/41 throughout; then IDLE.
- Back-to-back and cadence:
  - Push (0,0,8'h31), (5,7,8'h32), (1,1,8'h33) in consecutive cycles.
  - Expect windows of 1, 8 and 2 cycles with no gap; code_first pulses at cycles 0, 1 and 9 of the stream.
- Full FIFO:
  - Hold the feeder in a long window (len=7) and push 9 codewords with DEPTH=8 → the 9th is refused (in_ready=0).
  - A push coincident with a pop while full is also refused; fifo_count peaks at 8.
- End of stream:
  - Push (2,3,8'h24) then (0,0,8'h35) → the '$' window lasts 4 cycles, then stream_end=1, in_ready=0, and (0,0,8'h35) stays queued with fifo_count=1.
  - Pulse dec_finish → IDLE, then (0,0,8'h35) is issued.
- Reset mid-window: assert reset during cycle 2 of a len=5 window → outputs go to 0 asynchronously, fifo_count=0, and no remaining cycles are issued after release.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared types for the LZ77 decoder front end: codeword layout, end marker, feeder states.
package lz77_pkg;

  typedef struct packed {
    logic [3:0] pos;
    logic [2:0] len;
    logic [7:0] ch;
  } code_t;

  localparam logic [7:0] END_CHAR = 8'h24;

  typedef enum logic [1:0] {IDLE, HOLD, END} state_t;

endpackage

// File: rtl/lz77_code_fifo.sv
// Synchronous DEPTH-entry codeword FIFO; a push when full or a pop when empty is ignored.
module lz77_code_fifo
  import lz77_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  code_t                      wdata,
  input  logic                       pop,
  output code_t                      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  code_t         mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/lz77_code_feeder.sv
// Presents buffered codewords to the decoder, one per len+1-cycle window; parks after END_CHAR.
module lz77_code_feeder #(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] END_CHAR = lz77_pkg::END_CHAR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_pos,
  input  logic [2:0]             in_len,
  input  logic [7:0]             in_char,
  output logic [3:0]             code_pos,
  output logic [2:0]             code_len,
  output logic [7:0]             chardata,
  output logic                   code_valid,
  output logic                   code_first,
  output logic                   stream_end,
  input  logic                   dec_finish,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import lz77_pkg::*;

  state_t     state, state_nx;
  code_t      in_code, head;
  logic       full, empty, pop;
  logic [2:0] cnt;

  assign in_code = '{pos: in_pos, len: in_len, ch: in_char};

  lz77_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid & in_ready),
    .wdata (in_code),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign in_ready   = ~full & (state != END);
  assign code_valid = (state == HOLD);
  assign stream_end = (state == END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Pop decisions use the registered count, so a fresh push is never bypassed.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop      = 1'b1;
        state_nx = HOLD;
      end
      HOLD: if (cnt == '0) begin
        if (chardata == END_CHAR) state_nx = END;
        else if (!empty)          pop      = 1'b1;
        else                      state_nx = IDLE;
      end
      END:  if (dec_finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_pos   <= '0;
      code_len   <= '0;
      chardata   <= '0;
      code_first <= 1'b0;
      cnt        <= '0;
    end else begin
      code_first <= pop;
      if (pop) begin
        code_pos <= head.pos;
        code_len <= head.len;
        chardata <= head.ch;
        cnt      <= head.len;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
